// File: rtl/counter_ctrl.sv
// counter_ctrl: command sequencer that drives an 8-bit loadable counter (Data/load/enable) and watches its Q.
// Latency: LOAD and RUN_N complete with done one cycle after their last strobe; RUN_N 0 and NOP pulse done the cycle after accept.
// Backpressure: cmd_ready is high only in IDLE, so one command is in flight at a time. Optional wrap flag under COUNTER_CTRL_WRAP_DETECT_EN.
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Data,
  output logic             load,
  output logic             enable,
  output logic             busy,
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
  output logic             wrap,
`endif
  output logic             done
);

  localparam logic [1:0] OP_LOAD      = 2'd0;
  localparam logic [1:0] OP_RUN_N     = 2'd1;
  localparam logic [1:0] OP_RUN_UNTIL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_RUN_N     = 2'd2,
    ST_RUN_UNTIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             done_q, done_d;
  logic             accept;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign Data      = data_q;
  assign done      = done_q;

  // State and command registers; reset drops every strobe without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      target_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
      done_q      <= done_d;
    end
  end

  // Next-state and counter strobes; abort masks load/enable in the same cycle.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    done_d      = 1'b0;
    load        = 1'b0;
    enable      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort is ignored here; a command presented with it is accepted normally
        if (accept) begin
          unique case (cmd_op)
            OP_LOAD: begin
              data_d  = cmd_data;
              state_d = ST_LOAD;
            end
            OP_RUN_N: begin
              if (cmd_data == '0) begin
                done_d = 1'b1;
              end else begin
                remaining_d = cmd_data;
                state_d     = ST_RUN_N;
              end
            end
            OP_RUN_UNTIL: begin
              target_d = cmd_data;
              state_d  = ST_RUN_UNTIL;
            end
            default: begin
              done_d = 1'b1;   // NOP
            end
          endcase
        end
      end

      ST_LOAD: begin
        load    = !abort;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      ST_RUN_N: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          enable      = 1'b1;
          remaining_d = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN_UNTIL: begin
        // Stop on the cycle Q already equals target so the counter rests exactly there
        if (abort || (Q == target_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          enable = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef COUNTER_CTRL_WRAP_DETECT_EN
  logic wrap_q;

  assign wrap = wrap_q;

  // Sticky flag: counter is about to roll from all-ones to zero; cleared by the next command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else if (accept) begin
      wrap_q <= 1'b0;
    end else if (enable && (Q == '1)) begin
      wrap_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl with a behavioural loadable counter closing the loop.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// A watchdog bounds the run; every check steps the vector and miscompare counts.
module tb_counter_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       abort;
  logic [7:0] Q;
  logic [7:0] Data;
  logic       load;
  logic       enable;
  logic       busy;
  logic       done;
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
  logic       wrap;
`endif

  int vectors;
  int miscompares;
  int en_cnt;

  counter_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .Q         (Q),
    .Data      (Data),
    .load      (load),
    .enable    (enable),
    .busy      (busy),
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
    .wrap      (wrap),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The counter being sequenced: no reset of its own, so Q holds across controller reset.
  initial Q = 8'h00;
  always @(posedge clk) begin
    if (load)        Q <= Data;
    else if (enable) Q <= Q + 8'h01;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge (the DUT must be in IDLE), then withdraw it.
  task automatic issue(input logic [1:0] op, input logic [7:0] val);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = val;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_data  = 8'h00;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'd3;
    cmd_data    = 8'h00;
    abort       = 1'b0;

    // Reset state
    tick();
    check("rst_busy",   busy,   1'b0);
    check("rst_done",   done,   1'b0);
    check("rst_load",   load,   1'b0);
    check("rst_enable", enable, 1'b0);
    check("rst_data",   Data,   8'h00);
    reset = 1'b1;
    tick();
    check("rel_ready", cmd_ready, 1'b1);
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
    check("rst_wrap", wrap, 1'b0);
`endif

    // LOAD 0x55
    issue(2'd0, 8'h55);
    check("ld_load",  load,   1'b1);
    check("ld_data",  Data,   8'h55);
    check("ld_en",    enable, 1'b0);
    check("ld_busy",  busy,   1'b1);
    check("ld_ready", cmd_ready, 1'b0);
    check("ld_done0", done,   1'b0);
    tick();
    check("ld_q",     Q,      8'h55);
    check("ld_done",  done,   1'b1);
    check("ld_load0", load,   1'b0);
    check("ld_idle",  busy,   1'b0);
    tick();
    check("ld_done_1cyc", done, 1'b0);
    check("ld_busy_after", busy, 1'b0);

    // RUN_N 5 from 0x55, then back-to-back LOAD 0x10 in the done cycle
    issue(2'd1, 8'd5);
    en_cnt = 0;
    for (int i = 0; i < 20 && enable === 1'b1; i++) begin
      en_cnt++;
      if (load !== 1'b0) check("rn_load_excl", load, 1'b0);
      if (done !== 1'b0) check("rn_done_early", done, 1'b0);
      tick();
    end
    check("rn_en_cycles", en_cnt, 5);
    check("rn_q",     Q,      8'h5A);
    check("rn_done",  done,   1'b1);
    check("rn_ready", cmd_ready, 1'b1);
    issue(2'd0, 8'h10);
    check("b2b_load", load,   1'b1);
    check("b2b_data", Data,   8'h10);
    check("b2b_done0", done,  1'b0);
    tick();
    check("b2b_q",    Q,      8'h10);
    check("b2b_done", done,   1'b1);
    tick();

    // RUN_UNTIL 0x02 from 0xFC, wrapping through 0xFF/0x00
    issue(2'd0, 8'hFC);
    tick();
    check("ru_start_q", Q, 8'hFC);
    tick();
    issue(2'd2, 8'h02);
    en_cnt = 0;
    for (int i = 0; i < 20 && enable === 1'b1; i++) begin
      en_cnt++;
      tick();
    end
    check("ru_en_cycles", en_cnt, 6);
    check("ru_q_stop",    Q,      8'h02);
    check("ru_busy",      busy,   1'b1);
    check("ru_done0",     done,   1'b0);
    tick();
    check("ru_done",      done,   1'b1);
    check("ru_q_hold",    Q,      8'h02);
    check("ru_idle",      busy,   1'b0);
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
    check("ru_wrap_set",  wrap,   1'b1);
    tick();
    check("ru_wrap_sticky", wrap, 1'b1);
`endif

    // RUN_UNTIL with target already reached
    issue(2'd2, 8'h02);
    check("rueq_en",    enable, 1'b0);
    check("rueq_done0", done,   1'b0);
`ifdef COUNTER_CTRL_WRAP_DETECT_EN
    check("rueq_wrap_clr", wrap, 1'b0);
`endif
    tick();
    check("rueq_done",  done,   1'b1);
    check("rueq_en2",   enable, 1'b0);
    check("rueq_q",     Q,      8'h02);

    // RUN_N 0: done the cycle after accept, no enable
    issue(2'd1, 8'd0);
    check("rn0_done",  done,   1'b1);
    check("rn0_en",    enable, 1'b0);
    check("rn0_busy",  busy,   1'b0);
    tick();
    check("rn0_done_1cyc", done, 1'b0);
    check("rn0_q",     Q,      8'h02);

    // NOP presented with abort in IDLE is accepted normally
    abort = 1'b1;
    issue(2'd3, 8'h00);
    abort = 1'b0;
    check("nop_done",  done,   1'b1);
    check("nop_busy",  busy,   1'b0);

    // RUN_N 20 from 0x00 with abort on the 4th enable cycle
    issue(2'd0, 8'h00);
    tick();
    check("ab_start_q", Q, 8'h00);
    issue(2'd1, 8'd20);
    for (int i = 0; i < 3; i++) begin
      check("ab_en_pre", enable, 1'b1);
      tick();
    end
    abort = 1'b1;
    #1;
    check("ab_en_masked", enable, 1'b0);
    check("ab_load_masked", load, 1'b0);
    tick();
    abort = 1'b0;
    check("ab_q",      Q,      8'h03);
    check("ab_busy",   busy,   1'b0);
    check("ab_done",   done,   1'b1);
    check("ab_en",     enable, 1'b0);
    tick();

    // Asynchronous reset in the middle of RUN_N
    issue(2'd1, 8'd10);
    tick();
    tick();
    check("rr_en_before", enable, 1'b1);
    check("rr_q_before",  Q,      8'h05);
    #2;
    reset = 1'b0;
    #1;
    check("rr_en",   enable, 1'b0);
    check("rr_busy", busy,   1'b0);
    check("rr_load", load,   1'b0);
    check("rr_done", done,   1'b0);
    tick();
    check("rr_q_held", Q, 8'h05);
    reset = 1'b1;
    tick();
    check("rr_ready", cmd_ready, 1'b1);
    check("rr_q_after", Q, 8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
